// File: rtl/mul_booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// Booth digit codes, FSM states and digit-count helper.
package mul_booth_pkg;

    // Digit code layout is {neg, two, one}
    localparam logic [2:0] BOOTH_ZERO = 3'b000;
    localparam logic [2:0] BOOTH_P1   = 3'b001;
    localparam logic [2:0] BOOTH_P2   = 3'b010;
    localparam logic [2:0] BOOTH_M1   = 3'b101;
    localparam logic [2:0] BOOTH_M2   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Unsigned operands need one more digit to absorb the zero-extended top bits.
    function automatic int num_digits(input int width, input logic tc);
        return tc ? (width / 2) : (width / 2 + 1);
    endfunction

    function automatic logic [2:0] booth_encode(input logic [2:0] triplet);
        logic [2:0] code;
        case (triplet)
            3'b001, 3'b010: code = BOOTH_P1;
            3'b011:         code = BOOTH_P2;
            3'b100:         code = BOOTH_M2;
            3'b101, 3'b110: code = BOOTH_M1;
            default:        code = BOOTH_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Combinational radix-4 Booth partial-product generator: one triplet of the
// multiplier selects {0, +-A, +-2A}, sign-extended to the accumulator width.
module booth_r4_pp
    import mul_booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]         triplet_i,
    input  logic [WIDTH:0]     a_ext_i,
    output logic [2*WIDTH+3:0] pp_o
);

    localparam int PW = 2 * WIDTH + 4;

    logic [2:0]    code;
    logic [PW-1:0] a_sx;
    logic [PW-1:0] mag;

    assign code = booth_encode(triplet_i);
    assign a_sx = {{(PW - WIDTH - 1){a_ext_i[WIDTH]}}, a_ext_i};

    always_comb begin
        mag = '0;
        if (code[0]) begin
            mag = a_sx;
        end else if (code[1]) begin
            mag = a_sx << 1;
        end
        // Two's complement negation wraps cleanly in PW bits, even for -2*A_min
        pp_o = code[2] ? (~mag + PW'(1)) : mag;
    end

endmodule

// File: rtl/mul_booth_r4_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both
// sides; retires one Booth digit per clock into a registered accumulator.
module mul_booth_r4_seq
    import mul_booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);

    localparam int AW = WIDTH + 1;
    localparam int BW = WIDTH + 3;
    localparam int PW = 2 * WIDTH + 4;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("mul_booth_r4_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [2*WIDTH-1:0]  product_q;
    logic [AW-1:0]       a_ext_q;
    logic [BW-1:0]       b_q;
    logic                tc_q;
    logic [CW-1:0]       idx_q;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       acc_d;
    logic [PW-1:0]       pp;
    logic                last_digit;
    logic                ext_a;
    logic                ext_b;

    // b_q[0] is the implicit bit -1; the register shifts right two bits per
    // digit so the current triplet always sits at b_q[2:0].
    booth_r4_pp #(
        .WIDTH (WIDTH)
    ) u_pp (
        .triplet_i (b_q[2:0]),
        .a_ext_i   (a_ext_q),
        .pp_o      (pp)
    );

    assign acc_d      = acc_q + (pp << {idx_q, 1'b0});
    assign last_digit = (idx_q == CW'(num_digits(WIDTH, tc_q) - 1));
    assign ext_a      = in_tc & in_a[WIDTH-1];
    assign ext_b      = in_tc & in_b[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            a_ext_q     <= '0;
            b_q         <= '0;
            tc_q        <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_ext_q    <= {ext_a, in_a};
                        b_q        <= {{2{ext_b}}, in_b, 1'b0};
                        tc_q       <= in_tc;
                        idx_q      <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> 2;
                    idx_q <= idx_q + CW'(1);
                    if (last_digit) begin
                        product_q   <= acc_d[2*WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after the output handshake completes
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_product = product_q;

endmodule
